day3_edge_detector: RTL and testbench



---
 rtl/day3_pkg.sv | 10 +
 rtl/day3_sat_cnt.sv | 36 +++
 rtl/day3_edge_detector.sv | 88 ++++++++
 tb/tb_day3_edge_detector.sv | 132 +++++++++++++
 4 files changed

// File: rtl/day3_pkg.sv
// rtl/day3_pkg.sv - shared constants for the day3 edge detector
// Purpose: default counter width and synchronizer depth used by the
//          edge detector and its saturating counters.
// Ports:   none (package).
package day3_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/day3_sat_cnt.sv
// rtl/day3_sat_cnt.sv - saturating event counter with priority clear
// Purpose: counts inc_i pulses and holds at all-ones; clr_i zeroes the count
//          and wins over a simultaneous increment.
// Ports:   clk     - rising-edge clock
//          reset   - asynchronous active-low reset
//          inc_i   - increment request for this cycle
//          clr_i   - synchronous clear, priority over inc_i
//          cnt_o   - current count (W bits)
module day3_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_full) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/day3_edge_detector.sv
// rtl/day3_edge_detector.sv - level-to-strobe edge detector with edge counters
// Purpose: registers one-cycle pulses on 0->1 and 1->0 transitions of the
//          sampled input and keeps a saturating count per direction.
// Config:  DAY3_SYNC_EN - when defined, a_i passes through a reset-to-0
//          synchronizer of SYNC_STAGES flops before edge detection.
// Ports:   clk            - rising-edge clock
//          reset          - asynchronous active-low reset
//          a_i            - level input to monitor
//          clear_i        - synchronous clear of both counters
//          rising_edge_o  - one-cycle pulse on a rising sampled transition
//          falling_edge_o - one-cycle pulse on a falling sampled transition
//          rise_cnt_o     - saturating rising-edge count
//          fall_cnt_o     - saturating falling-edge count
module day3_edge_detector
  import day3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic             clear_i,
  output logic             rising_edge_o,
  output logic             falling_edge_o,
  output logic [CNT_W-1:0] rise_cnt_o,
  output logic [CNT_W-1:0] fall_cnt_o
);

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic r_a_q;
  logic r_rise;
  logic r_fall;

`ifdef DAY3_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];
`else
  assign w_s = a_i;
`endif

  // History resets to 0, so a high input at the first sample counts as a rise.
  assign w_rise = w_s & ~r_a_q;
  assign w_fall = ~w_s & r_a_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_q  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_a_q  <= w_s;
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  assign rising_edge_o  = r_rise;
  assign falling_edge_o = r_fall;

  // Counters advance on the same edge that raises the matching pulse.
  day3_sat_cnt #(.W(CNT_W)) u_rise_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_rise),
    .clr_i (clear_i),
    .cnt_o (rise_cnt_o)
  );

  day3_sat_cnt #(.W(CNT_W)) u_fall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_fall),
    .clr_i (clear_i),
    .cnt_o (fall_cnt_o)
  );

endmodule

// File: tb/tb_day3_edge_detector.sv
// tb/tb_day3_edge_detector.sv - scoreboard bench for day3_edge_detector
module tb_day3_edge_detector;

  localparam int W = 2;

  typedef struct packed {
    logic         r;
    logic         f;
    logic [W-1:0] rc;
    logic [W-1:0] fc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         a_i;
  logic         clear_i;
  logic         rising_edge_o;
  logic         falling_edge_o;
  logic [W-1:0] rise_cnt_o;
  logic [W-1:0] fall_cnt_o;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec      = 0;
  event ev_async;

  day3_edge_detector #(.CNT_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .clear_i        (clear_i),
    .rising_edge_o  (rising_edge_o),
    .falling_edge_o (falling_edge_o),
    .rise_cnt_o     (rise_cnt_o),
    .fall_cnt_o     (fall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per clock edge (or async reset event).
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk or ev_async);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = '{r: rising_edge_o, f: falling_edge_o, rc: rise_cnt_o, fc: fall_cnt_o};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL out_vec%0d: got rise=%b fall=%b rcnt=%0d fcnt=%0d expected rise=%b fall=%b rcnt=%0d fcnt=%0d",
                   vec, act.r, act.f, act.rc, act.fc, e.r, e.f, e.rc, e.fc);
        end
        if (rising_edge_o && falling_edge_o) begin
          failures++;
          $display("FAIL exclusive: rise=%b fall=%b both high", rising_edge_o, falling_edge_o);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic a, input logic clr,
                      input logic er, input logic ef,
                      input logic [W-1:0] erc, input logic [W-1:0] efc);
    @(negedge clk);
    reset   = rst;
    a_i     = a;
    clear_i = clr;
    vec++;
    q.push_back('{r: er, f: ef, rc: erc, fc: efc});
    @(posedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    a_i     = 1'b0;
    clear_i = 1'b0;

    // reset held, then released with input low
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // rise held three cycles
    step(1, 1, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    // fall
    step(1, 0, 0, 0, 1, 1, 1);
    // toggle every cycle for six cycles, rise count saturates at 3
    step(1, 1, 0, 1, 0, 2, 1);
    step(1, 0, 0, 0, 1, 2, 2);
    step(1, 1, 0, 1, 0, 3, 2);
    step(1, 0, 0, 0, 1, 3, 3);
    step(1, 1, 0, 1, 0, 3, 3);
    step(1, 0, 0, 0, 1, 3, 3);
    // clear coincident with a rising edge: pulse kept, counters zeroed
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1, 1);

    // async reset while the rising pulse is high
    #2;
    reset = 1'b0;
    vec++;
    q.push_back('{r: 1'b0, f: 1'b0, rc: '0, fc: '0});
    ->ev_async;
    #3;

    // input high across reset release: exactly one rising pulse
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
